// File: rtl/axi_dma_copy128_pkg.sv
// Shared types and constants for the 128-bit AXI memory-to-memory copier.
// FSM encodings, AXI field widths/codes and the burst sizing helper.
package axi_dma_copy128_pkg;

    localparam int ALEN_W   = 8;
    localparam int ASIZE_W  = 3;
    localparam int ABURST_W = 2;
    localparam int RESP_W   = 2;

    localparam logic [ASIZE_W-1:0]  SIZE_16B   = 3'd4;
    localparam logic [ABURST_W-1:0] BURST_INCR = 2'd1;
    localparam logic [RESP_W-1:0]   RESP_OKAY  = 2'd0;

    localparam int PAGE_BYTES = 4096;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } top_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP
    } wr_state_t;

    // Beats in the next burst: capped by what is left, the burst limit
    // and the distance to the next 4 KB page.
    function automatic logic [8:0] burst_beats(
        input logic [31:0] remain,
        input logic [11:0] off,
        input logic [31:0] max_b
    );
        logic [31:0] to_page;
        logic [31:0] b;
        to_page = (32'(PAGE_BYTES) - {20'd0, off}) >> 4;
        b = remain;
        if (max_b < b) b = max_b;
        if (to_page < b) b = to_page;
        return b[8:0];
    endfunction

endpackage

// File: rtl/axi_dma_copy128_fifo.sv
// Staging FIFO between the read and write sides of the copier.
// Show-ahead read port; count is one bit wider than the pointers.
module axi_dma_copy128_fifo
    import axi_dma_copy128_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int BW    = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [BW-1:0]          i_data,
    input  logic                   i_pop,
    output logic [BW-1:0]          o_data,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [BW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push && (r_count != CW'(DEPTH));
    assign w_pop   = i_pop && (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Data storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    // Pointers and occupancy; simultaneous push and pop keep the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= nxt(r_wr_ptr);
            if (w_pop) r_rd_ptr <= nxt(r_rd_ptr);
            if (w_push && !w_pop) r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/axi_dma_copy128.sv
// AXI4 memory-to-memory copier, 16-byte beats, 4 KB-safe INCR bursts.
// Read and write sides run concurrently through a staging FIFO.
module axi_dma_copy128
    import axi_dma_copy128_pkg::*;
#(
    parameter int BW_ADDR     = 32,
    parameter int BW_AXI_DATA = 128,
    parameter int BW_AXI_TID  = 4,
    parameter int AXI_ID      = 0,
    parameter int MAX_BURST   = 16,
    parameter int FIFO_DEPTH  = 32,
    parameter int BW_NUM_BEAT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [BW_ADDR-1:0]       cmd_src,
    input  logic [BW_ADDR-1:0]       cmd_dst,
    input  logic [BW_NUM_BEAT-1:0]   cmd_num_beat,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [BW_AXI_TID-1:0]    txarid,
    output logic [BW_ADDR-1:0]       txaraddr,
    output logic [ALEN_W-1:0]        txarlen,
    output logic [ASIZE_W-1:0]       txarsize,
    output logic [ABURST_W-1:0]      txarburst,
    output logic                     txarvalid,
    input  logic                     txarready,
    input  logic [BW_AXI_TID-1:0]    txrid,
    input  logic [BW_AXI_DATA-1:0]   txrdata,
    input  logic [RESP_W-1:0]        txrresp,
    input  logic                     txrlast,
    input  logic                     txrvalid,
    output logic                     txrready,
    output logic [BW_AXI_TID-1:0]    txawid,
    output logic [BW_ADDR-1:0]       txawaddr,
    output logic [ALEN_W-1:0]        txawlen,
    output logic [ASIZE_W-1:0]       txawsize,
    output logic [ABURST_W-1:0]      txawburst,
    output logic                     txawvalid,
    input  logic                     txawready,
    output logic [BW_AXI_TID-1:0]    txwid,
    output logic [BW_AXI_DATA-1:0]   txwdata,
    output logic [BW_AXI_DATA/8-1:0] txwstrb,
    output logic                     txwlast,
    output logic                     txwvalid,
    input  logic                     txwready,
    input  logic [BW_AXI_TID-1:0]    txbid,
    input  logic [RESP_W-1:0]        txbresp,
    input  logic                     txbvalid,
    output logic                     txbready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    top_state_t r_state, w_state_nx;
    rd_state_t  r_rstate, w_rstate_nx;
    wr_state_t  r_wstate, w_wstate_nx;

    logic [BW_ADDR-1:0]     r_rd_addr, r_wr_addr;
    logic [BW_ADDR-1:0]     r_araddr, r_awaddr;
    logic [BW_NUM_BEAT-1:0] r_rd_left, r_wr_left;
    logic [ALEN_W-1:0]      r_arlen, r_awlen, r_wcnt;
    logic                   r_error;

    logic [CW-1:0]          w_count, w_free;
    logic [8:0]             w_rd_beats, w_wr_beats;
    logic [BW_AXI_DATA-1:0] w_fifo_data;
    logic w_accept, w_misalign, w_zero;
    logic w_ar_hs, w_aw_hs, w_push, w_pop, w_b_hs, w_last_b;
    logic w_unused;

    assign w_unused   = ^{txrid, txbid};
    assign w_misalign = (cmd_src[3:0] != 4'd0) || (cmd_dst[3:0] != 4'd0);
    assign w_zero     = (cmd_num_beat == '0);
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_ar_hs    = txarvalid && txarready;
    assign w_aw_hs    = txawvalid && txawready;
    assign w_push     = txrvalid && txrready;
    assign w_pop      = txwvalid && txwready;
    assign w_b_hs     = txbvalid && txbready;
    assign w_last_b   = w_b_hs && (r_wr_left == '0);
    assign w_free     = CW'(FIFO_DEPTH) - w_count;

    assign w_rd_beats = burst_beats(32'(r_rd_left), r_rd_addr[11:0],
                                    32'(MAX_BURST));
    assign w_wr_beats = burst_beats(32'(r_wr_left), r_wr_addr[11:0],
                                    32'(MAX_BURST));

    assign cmd_ready = (r_state == S_IDLE) && !rst;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_FINISH);
    assign error     = r_error;

    assign txarid    = BW_AXI_TID'(AXI_ID);
    assign txaraddr  = r_araddr;
    assign txarlen   = r_arlen;
    assign txarsize  = SIZE_16B;
    assign txarburst = BURST_INCR;
    assign txarvalid = (r_rstate == R_ADDR);
    assign txrready  = (r_rstate == R_DATA);

    assign txawid    = BW_AXI_TID'(AXI_ID);
    assign txawaddr  = r_awaddr;
    assign txawlen   = r_awlen;
    assign txawsize  = SIZE_16B;
    assign txawburst = BURST_INCR;
    assign txawvalid = (r_wstate == W_ADDR);

    assign txwid    = BW_AXI_TID'(AXI_ID);
    assign txwvalid = (r_wstate == W_DATA);
    assign txwdata  = txwvalid ? w_fifo_data : '0;
    assign txwstrb  = '1;
    assign txwlast  = txwvalid && (r_wcnt == r_awlen);
    assign txbready = (r_wstate == W_RESP);

    axi_dma_copy128_fifo #(
        .DEPTH (FIFO_DEPTH),
        .BW    (BW_AXI_DATA)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (txrdata),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_count (w_count)
    );

    // State registers of the command, read and write machines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rstate <= R_IDLE;
            r_wstate <= W_IDLE;
        end else begin
            r_state  <= w_state_nx;
            r_rstate <= w_rstate_nx;
            r_wstate <= w_wstate_nx;
        end
    end

    // Command sequencing: bad or empty commands finish without traffic
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:
                if (w_accept)
                    w_state_nx = (w_misalign || w_zero) ? S_FINISH : S_RUN;
            S_RUN:    if (w_last_b) w_state_nx = S_FINISH;
            S_FINISH: w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    // Read side: request a burst only once the FIFO can hold all of it
    always_comb begin
        w_rstate_nx = r_rstate;
        case (r_rstate)
            R_IDLE:
                if (r_state == S_RUN && r_rd_left != '0 &&
                    32'(w_free) >= 32'(w_rd_beats))
                    w_rstate_nx = R_ADDR;
            R_ADDR:  if (txarready) w_rstate_nx = R_DATA;
            R_DATA:  if (txrvalid && txrlast) w_rstate_nx = R_IDLE;
            default: w_rstate_nx = R_IDLE;
        endcase
    end

    // Write side: request a burst only once the FIFO holds all its data
    always_comb begin
        w_wstate_nx = r_wstate;
        case (r_wstate)
            W_IDLE:
                if (r_state == S_RUN && r_wr_left != '0 &&
                    32'(w_count) >= 32'(w_wr_beats))
                    w_wstate_nx = W_ADDR;
            W_ADDR:  if (txawready) w_wstate_nx = W_DATA;
            W_DATA:  if (w_pop && txwlast) w_wstate_nx = W_RESP;
            W_RESP:  if (txbvalid) w_wstate_nx = W_IDLE;
            default: w_wstate_nx = W_IDLE;
        endcase
    end

    // Read address/length bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_addr <= '0;
            r_rd_left <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
        end else begin
            if (w_accept) begin
                r_rd_addr <= cmd_src;
                r_rd_left <= w_misalign ? '0 : cmd_num_beat;
            end
            if (r_rstate == R_IDLE && w_rstate_nx == R_ADDR) begin
                r_araddr <= r_rd_addr;
                r_arlen  <= ALEN_W'(w_rd_beats - 9'd1);
            end
            if (w_ar_hs) begin
                r_rd_addr <= r_rd_addr + BW_ADDR'({r_arlen, 4'd0})
                           + BW_ADDR'(16);
                r_rd_left <= r_rd_left - BW_NUM_BEAT'(r_arlen)
                           - BW_NUM_BEAT'(1);
            end
        end
    end

    // Write address/length bookkeeping and in-burst beat counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_addr <= '0;
            r_wr_left <= '0;
            r_awaddr  <= '0;
            r_awlen   <= '0;
            r_wcnt    <= '0;
        end else begin
            if (w_accept) begin
                r_wr_addr <= cmd_dst;
                r_wr_left <= w_misalign ? '0 : cmd_num_beat;
            end
            if (r_wstate == W_IDLE && w_wstate_nx == W_ADDR) begin
                r_awaddr <= r_wr_addr;
                r_awlen  <= ALEN_W'(w_wr_beats - 9'd1);
            end
            if (w_aw_hs) begin
                r_wr_addr <= r_wr_addr + BW_ADDR'({r_awlen, 4'd0})
                           + BW_ADDR'(16);
                r_wr_left <= r_wr_left - BW_NUM_BEAT'(r_awlen)
                           - BW_NUM_BEAT'(1);
                r_wcnt    <= '0;
            end
            if (w_pop) r_wcnt <= r_wcnt + ALEN_W'(1);
        end
    end

    // Sticky error: cleared by a new command, set by bad responses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_error <= 1'b0;
        end else begin
            if (w_accept) r_error <= w_misalign;
            if (w_push && txrresp != RESP_OKAY) r_error <= 1'b1;
            if (w_b_hs && txbresp != RESP_OKAY) r_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_dma_copy128.sv
// Bench for axi_dma_copy128: AXI memory responder plus scoreboard.
// Expected AR/AW bursts and W data are queued per command.
module tb_axi_dma_copy128;

    logic clk = 1'b0;
    logic rst;
    logic cmd_valid, cmd_ready;
    logic [31:0] cmd_src, cmd_dst;
    logic [15:0] cmd_num_beat;
    logic busy, done, error;
    logic [3:0] txarid, txrid, txawid, txwid, txbid;
    logic [31:0] txaraddr, txawaddr;
    logic [7:0] txarlen, txawlen;
    logic [2:0] txarsize, txawsize;
    logic [1:0] txarburst, txawburst, txrresp, txbresp;
    logic txarvalid, txarready, txrlast, txrvalid, txrready;
    logic txawvalid, txawready, txwlast, txwvalid, txwready;
    logic txbvalid, txbready;
    logic [127:0] txrdata, txwdata;
    logic [15:0] txwstrb;

    always #5 clk = ~clk;

    axi_dma_copy128 dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst),
        .cmd_num_beat(cmd_num_beat),
        .busy(busy), .done(done), .error(error),
        .txarid(txarid), .txaraddr(txaraddr), .txarlen(txarlen),
        .txarsize(txarsize), .txarburst(txarburst),
        .txarvalid(txarvalid), .txarready(txarready),
        .txrid(txrid), .txrdata(txrdata), .txrresp(txrresp),
        .txrlast(txrlast), .txrvalid(txrvalid), .txrready(txrready),
        .txawid(txawid), .txawaddr(txawaddr), .txawlen(txawlen),
        .txawsize(txawsize), .txawburst(txawburst),
        .txawvalid(txawvalid), .txawready(txawready),
        .txwid(txwid), .txwdata(txwdata), .txwstrb(txwstrb),
        .txwlast(txwlast), .txwvalid(txwvalid), .txwready(txwready),
        .txbid(txbid), .txbresp(txbresp), .txbvalid(txbvalid),
        .txbready(txbready)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } burst_t;

    burst_t       exp_ar[$], exp_aw[$], rq[$], wq[$];
    logic [127:0] exp_w[$];
    logic [127:0] wmem [logic [31:0]];
    int bq = 0;
    int ar_n = 0, aw_n = 0, b_n = 0;
    int berr_idx = -1;
    bit ar_rand = 0, w_rand = 0;

    function automatic logic [127:0] pat(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_1234, a + 32'h1357_9BDF};
    endfunction

    function automatic int chunk(input logic [31:0] a, input int rem);
        int room;
        int c;
        room = (4096 - int'(a[11:0])) / 16;
        c = rem;
        if (c > 16) c = 16;
        if (c > room) c = room;
        return c;
    endfunction

    // Queue the bursts and data the copier is expected to produce
    task automatic plan(input logic [31:0] src, input logic [31:0] dst,
                        input int n);
        logic [31:0] a;
        int r;
        int c;
        a = src;
        r = n;
        while (r > 0) begin
            c = chunk(a, r);
            exp_ar.push_back('{addr: a, len: 8'(c - 1)});
            a = a + 32'(c * 16);
            r = r - c;
        end
        a = dst;
        r = n;
        while (r > 0) begin
            c = chunk(a, r);
            exp_aw.push_back('{addr: a, len: 8'(c - 1)});
            a = a + 32'(c * 16);
            r = r - c;
        end
        for (int i = 0; i < n; i++) exp_w.push_back(pat(src + 32'(i * 16)));
    endtask

    // AXI slave memory: samples handshakes at negedge, acts after posedge
    initial begin
        logic s_ar, s_r, s_aw, s_w, s_b, s_rst, s_wlast, stall_ar;
        logic [31:0] s_araddr, s_awaddr, a;
        logic [7:0] s_arlen, s_awlen;
        logic [127:0] s_wdata;
        logic [15:0] s_wstrb;
        logic [8:0] s_arattr, s_awattr;
        logic [40:0] stall_v;
        burst_t e;
        int rbeat, wbeat;
        rbeat = 0;
        wbeat = 0;
        stall_ar = 0;
        stall_v = '0;
        txarready = 0; txrvalid = 0; txrdata = '0; txrresp = 0;
        txrlast = 0; txrid = 0; txawready = 0; txwready = 0;
        txbvalid = 0; txbresp = 0; txbid = 0;
        forever begin
            @(negedge clk);
            s_rst = rst;
            s_ar = txarvalid && txarready;
            s_r = txrvalid && txrready;
            s_aw = txawvalid && txawready;
            s_w = txwvalid && txwready;
            s_b = txbvalid && txbready;
            s_araddr = txaraddr; s_arlen = txarlen;
            s_awaddr = txawaddr; s_awlen = txawlen;
            s_arattr = {txarsize, txarburst, txarid};
            s_awattr = {txawsize, txawburst, txawid};
            s_wdata = txwdata; s_wlast = txwlast; s_wstrb = txwstrb;
            if (stall_ar && !rst)
                chk("ar_hold", {txarvalid, txaraddr, txarlen}, stall_v);
            stall_ar = txarvalid && !txarready;
            stall_v = {1'b1, txaraddr, txarlen};
            @(posedge clk);
            #1;
            if (s_rst) begin
                rq.delete(); wq.delete();
                bq = 0; rbeat = 0; wbeat = 0; stall_ar = 0;
            end else begin
                if (s_r) begin
                    if (rbeat == int'(rq[0].len)) begin
                        void'(rq.pop_front());
                        rbeat = 0;
                    end else rbeat++;
                end
                if (s_ar) begin
                    ar_n++;
                    chk("ar_outstanding", rq.size(), 0);
                    chk("ar_4k", (int'(s_araddr[11:0]) +
                        (int'(s_arlen) + 1) * 16) > 4096, 0);
                    chk("ar_attr", s_arattr, {3'd4, 2'd1, 4'd0});
                    rq.push_back('{addr: s_araddr, len: s_arlen});
                    if (exp_ar.size() == 0) chk("ar_extra", 1, 0);
                    else begin
                        e = exp_ar.pop_front();
                        chk("ar_addr", s_araddr, e.addr);
                        chk("ar_len", s_arlen, e.len);
                    end
                end
                if (s_b) begin
                    bq--;
                    b_n++;
                end
                if (s_aw) begin
                    aw_n++;
                    chk("aw_outstanding", wq.size() + bq, 0);
                    chk("aw_4k", (int'(s_awaddr[11:0]) +
                        (int'(s_awlen) + 1) * 16) > 4096, 0);
                    chk("aw_attr", s_awattr, {3'd4, 2'd1, 4'd0});
                    wq.push_back('{addr: s_awaddr, len: s_awlen});
                    if (exp_aw.size() == 0) chk("aw_extra", 1, 0);
                    else begin
                        e = exp_aw.pop_front();
                        chk("aw_addr", s_awaddr, e.addr);
                        chk("aw_len", s_awlen, e.len);
                    end
                end
                if (s_w) begin
                    if (wq.size() == 0) chk("w_before_aw", 1, 0);
                    else begin
                        a = wq[0].addr + 32'(wbeat * 16);
                        wmem[a] = s_wdata;
                        chk("w_last", s_wlast, wbeat == int'(wq[0].len));
                        chk("w_strb", s_wstrb, 16'hFFFF);
                        if (exp_w.size() == 0) chk("w_extra", 1, 0);
                        else chk("w_data", s_wdata, exp_w.pop_front());
                        if (wbeat == int'(wq[0].len)) begin
                            void'(wq.pop_front());
                            wbeat = 0;
                            bq++;
                        end else wbeat++;
                    end
                end
            end
            txarready = s_rst ? 1'b0 :
                        (ar_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
            txawready = !s_rst;
            txwready = s_rst ? 1'b0 :
                       (w_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
            txrvalid = rq.size() > 0;
            txrdata = txrvalid ? pat(rq[0].addr + 32'(rbeat * 16)) : '0;
            txrlast = txrvalid && (rbeat == int'(rq[0].len));
            txbvalid = bq > 0;
            txbresp = (txbvalid && b_n == berr_idx) ? 2'b10 : 2'b00;
        end
    end

    task automatic send(input logic [31:0] s, input logic [31:0] d,
                        input logic [15:0] n);
        bit ok;
        @(posedge clk);
        #1;
        cmd_valid = 1; cmd_src = s; cmd_dst = d; cmd_num_beat = n;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        chk("cmd_accept", ok, 1);
        @(posedge clk);
        #1;
        cmd_valid = 0;
    endtask

    task automatic wait_done(input int limit, output int nd,
                             output logic e);
        int post;
        post = 0;
        nd = 0;
        e = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                e = error;
            end
            if (nd > 0) post++;
            if (post > 6) break;
        end
    endtask

    task automatic chk_copy(input logic [31:0] s, input logic [31:0] d,
                            input int n);
        int bad;
        logic [31:0] a;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            a = d + 32'(i * 16);
            if (!wmem.exists(a)) bad++;
            else if (wmem[a] !== pat(s + 32'(i * 16))) bad++;
        end
        chk("copy_intact", bad, 0);
    endtask

    task automatic flush_sb();
        exp_ar.delete();
        exp_aw.delete();
        exp_w.delete();
    endtask

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        int n;
        bit ar_r;
        bit w_r;
        int berr;
        int n_ar;
        int n_aw;
        logic err;
    } vec_t;

    vec_t tv[5];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd, ar0, aw0;
        logic e;
        tv[0] = '{32'h1000, 32'h8000, 20, 0, 0, -1, 2, 2, 1'b0};
        tv[1] = '{32'h0FC0, 32'h2000, 8, 0, 0, -1, 2, 1, 1'b0};
        tv[2] = '{32'h3000, 32'h5FA0, 64, 1, 1, -1, 4, 5, 1'b0};
        tv[3] = '{32'h4000, 32'h6000, 40, 0, 0, 1, 3, 3, 1'b1};
        tv[4] = '{32'h7000, 32'h7800, 0, 0, 0, -1, 0, 0, 1'b0};

        rst = 1; cmd_valid = 0; cmd_src = 0; cmd_dst = 0; cmd_num_beat = 0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {cmd_ready, busy, done, error, txarvalid,
            txawvalid, txwvalid, txrready, txbready, txaraddr, txawaddr,
            txarlen, txawlen}, 0);
        chk("reset_wdata", txwdata, 0);
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("idle_ready", {cmd_ready, busy}, 2'b10);

        for (int v = 0; v < 5; v++) begin
            ar0 = ar_n; aw0 = aw_n; b_n = 0;
            berr_idx = tv[v].berr; ar_rand = tv[v].ar_r; w_rand = tv[v].w_r;
            wmem.delete();
            plan(tv[v].src, tv[v].dst, tv[v].n);
            send(tv[v].src, tv[v].dst, 16'(tv[v].n));
            wait_done(4000, nd, e);
            chk($sformatf("v%0d_done_cnt", v), nd, 1);
            chk($sformatf("v%0d_error", v), e, tv[v].err);
            chk($sformatf("v%0d_ar_cnt", v), ar_n - ar0, tv[v].n_ar);
            chk($sformatf("v%0d_aw_cnt", v), aw_n - aw0, tv[v].n_aw);
            chk($sformatf("v%0d_sb_left", v),
                exp_ar.size() + exp_aw.size() + exp_w.size(), 0);
            chk_copy(tv[v].src, tv[v].dst, tv[v].n);
            chk($sformatf("v%0d_idle", v), {busy, cmd_ready}, 2'b01);
            flush_sb();
        end
        ar_rand = 0; w_rand = 0; berr_idx = -1;

        ar0 = ar_n; aw0 = aw_n;
        send(32'h1004, 32'h8000, 16'd8);
        @(negedge clk);
        chk("mis_finish", {done, error, busy}, 3'b111);
        nd = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("mis_single_done", nd, 0);
        chk("mis_no_axi", (ar_n - ar0) + (aw_n - aw0), 0);
        chk("mis_err_sticky", error, 1);

        ar0 = ar_n; b_n = 0; nd = 0;
        wmem.delete();
        plan(32'h1000, 32'h9000, 40);
        send(32'h1000, 32'h9000, 16'd40);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (done) nd++;
            if (ar_n >= ar0 + 2) break;
        end
        chk("rst_reach_ar2", ar_n - ar0 >= 2, 1);
        @(negedge clk);
        chk("rst_in_rdata", txrready, 1);
        @(posedge clk);
        #1;
        rst = 1;
        @(negedge clk);
        chk("rst_mid_outs", {busy, done, error, txarvalid, txawvalid,
            txwvalid, txrready, txbready, cmd_ready}, 0);
        flush_sb();
        wmem.delete();
        @(posedge clk);
        #1;
        rst = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("rst_no_done", nd, 0);
        chk("rst_no_writes", wmem.num(), 0);

        plan(32'h2000, 32'hA000, 4);
        send(32'h2000, 32'hA000, 16'd4);
        wait_done(1000, nd, e);
        chk("restart_done_cnt", nd, 1);
        chk("restart_error", e, 0);
        chk_copy(32'h2000, 32'hA000, 4);
        chk("restart_only_new", wmem.num(), 4);
        chk("restart_sb_left",
            exp_ar.size() + exp_aw.size() + exp_w.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
